// File: rtl/ub_ctrl_pkg.sv
// ub_ctrl_pkg: shared types and widths for the unified-buffer schedule controller.
package ub_ctrl_pkg;
  localparam int CTRL_W = 16;
  localparam int NUM_DIMS = 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  typedef logic [CTRL_W-1:0] ctrl_t;
  typedef logic [NUM_DIMS-1:0][CTRL_W-1:0] ctrl_vars_t;
  // Indices are only visible on the port while the matching strobe is high.
  function automatic ctrl_vars_t pack_vars(input logic en, input ctrl_t x, input ctrl_t y);
    return en ? {y, x, ctrl_t'(0)} : '0;
  endfunction
endpackage

// File: rtl/ub_schedule_ctrl_if.sv
// ub_schedule_ctrl_if: control inputs and buffer-side strobes/indices of the schedule controller.
interface ub_schedule_ctrl_if import ub_ctrl_pkg::*; ();
  logic flush;
  logic start;
  logic stall;
  logic write_wen;
  ctrl_vars_t write_ctrl_vars;
  logic read_ren;
  ctrl_vars_t read_ctrl_vars;
  logic busy;
  logic done;
  modport master (
    input flush, start, stall,
    output write_wen, write_ctrl_vars, read_ren, read_ctrl_vars, busy, done
  );
  modport slave (
    output flush, start, stall,
    input write_wen, write_ctrl_vars, read_ren, read_ctrl_vars, busy, done
  );
endinterface

// File: rtl/ub_loop_counter.sv
// ub_loop_counter: two-level loop nest, x innermost, wrapping to zero after the last point.
module ub_loop_counter import ub_ctrl_pkg::*; #(
  parameter int X_EXTENT = 64,
  parameter int Y_EXTENT = 64
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  logic  en,
  output ctrl_t x,
  output ctrl_t y,
  output logic  last
);
  ctrl_t x_q, x_d, y_q, y_d;
  logic x_last, y_last;
  always_comb begin
    x_last = x_q == CTRL_W'(X_EXTENT - 1);
    y_last = y_q == CTRL_W'(Y_EXTENT - 1);
    x_d = clr ? '0 : en ? (x_last ? '0 : x_q + ctrl_t'(1)) : x_q;
    y_d = clr ? '0 : (en && x_last) ? (y_last ? '0 : y_q + ctrl_t'(1)) : y_q;
    last = x_last && y_last;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/ub_schedule_ctrl.sv
// ub_schedule_ctrl: drives producer writes over an X*Y loop nest and replays each
// point as a consumer read RD_DELAY active cycles later.
module ub_schedule_ctrl import ub_ctrl_pkg::*; #(
  parameter int X_EXTENT = 64,
  parameter int Y_EXTENT = 64,
  parameter int RD_DELAY = 2
) (
  input logic clk,
  input logic rst_n,
  ub_schedule_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic [RD_DELAY-1:0] vld_q, vld_d;
  logic wen, ren, wr_last, rd_last;
  ctrl_t wx, wy, rx, ry;
  ub_loop_counter #(.X_EXTENT(X_EXTENT), .Y_EXTENT(Y_EXTENT)) u_wr (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .en(wen), .x(wx), .y(wy), .last(wr_last)
  );
  ub_loop_counter #(.X_EXTENT(X_EXTENT), .Y_EXTENT(Y_EXTENT)) u_rd (
    .clk(clk), .rst_n(rst_n), .clr(bus.flush), .en(ren), .x(rx), .y(ry), .last(rd_last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= vld_d;
    end
  // The valid pipe only advances on active cycles, so stalls stretch the delay without losing entries.
  always_comb begin
    state_d = bus.flush ? IDLE :
              state_q == IDLE  ? (bus.start ? RUN : IDLE) :
              state_q == RUN   ? ((wen && wr_last) ? DRAIN : RUN) :
              state_q == DRAIN ? ((ren && rd_last) ? DONE : DRAIN) : IDLE;
    vld_d = bus.flush ? '0 : bus.stall ? vld_q : (vld_q << 1) | RD_DELAY'(wen);
  end
  always_comb begin
    wen = state_q == RUN && !bus.stall;
    ren = vld_q[RD_DELAY-1] && !bus.stall;
    bus.write_wen = wen;
    bus.read_ren = ren;
    bus.write_ctrl_vars = pack_vars(wen, wx, wy);
    bus.read_ctrl_vars = pack_vars(ren, rx, ry);
    bus.busy = state_q == RUN || state_q == DRAIN;
    bus.done = state_q == DONE;
  end
endmodule

// File: tb/tb_ub_schedule_ctrl.sv
// tb_ub_schedule_ctrl: scoreboard bench for a 4x4 and a default 64x64 schedule controller.
module tb_ub_schedule_ctrl;
  import ub_ctrl_pkg::*;
  typedef struct {int cyc; int x; int y;} ev_t;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t wq4[$], rq4[$], wq64[$], rq64[$];
  int dq4[$], dq64[$];
  ub_schedule_ctrl_if if4();
  ub_schedule_ctrl_if if64();
  ub_schedule_ctrl #(.X_EXTENT(4), .Y_EXTENT(4), .RD_DELAY(2)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  ub_schedule_ctrl dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_stb(input string nm, ref ev_t q[$], input logic stb, input ctrl_vars_t v);
    ev_t e;
    ctrl_vars_t ev;
    checks++;
    if (stb) begin
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s: strobe at cycle %0d vars %h, expected no strobe", nm, cyc, v);
      end else begin
        e = q.pop_front();
        ev = {16'(e.y), 16'(e.x), 16'd0};
        if (e.cyc != cyc || v !== ev) begin
          errors++;
          $display("FAIL %s: got cycle %0d vars %h, expected cycle %0d vars %h", nm, cyc, v, e.cyc, ev);
        end
      end
    end else if (v !== '0) begin
      errors++;
      $display("FAIL %s_idle: vars %h at cycle %0d with strobe low, expected 0", nm, v, cyc);
    end
  endtask

  task automatic chk_done(input string nm, ref int q[$], input logic dn, input logic bsy);
    int e;
    if (dn) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL %s: done at cycle %0d, expected none", nm, cyc);
      end else begin
        e = q.pop_front();
        if (e != cyc || bsy !== 1'b0) begin
          errors++;
          $display("FAIL %s: done at cycle %0d busy %0b, expected cycle %0d busy 0", nm, cyc, bsy, e);
        end
      end
    end
  endtask

  always @(negedge clk)
    if (rst_n) begin
      chk_stb("wr4", wq4, if4.write_wen, if4.write_ctrl_vars);
      chk_stb("rd4", rq4, if4.read_ren, if4.read_ctrl_vars);
      chk_done("done4", dq4, if4.done, if4.busy);
      chk_stb("wr64", wq64, if64.write_wen, if64.write_ctrl_vars);
      chk_stb("rd64", rq64, if64.read_ren, if64.read_ctrl_vars);
      chk_done("done64", dq64, if64.done, if64.busy);
    end

  task automatic check_val(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic expect_empty(input string nm);
    check_val(nm, wq4.size() + rq4.size() + dq4.size() + wq64.size() + rq64.size() + dq64.size(), 0);
  endtask

  task automatic launch(input bit big, output int t0);
    @(posedge clk);
    #1;
    if (big) if64.start = 1;
    else if4.start = 1;
    t0 = cyc;
    @(posedge clk);
    #1;
    if4.start = 0;
    if64.start = 0;
  endtask

  // Expected strobes: write k at t0+1+k, read k at t0+3+k, both pushed back by a stall window.
  task automatic push_run(input bit big, input int t0, input int nx, input int nw, input int nr,
                          input int st_after, input int st_len, input bit with_done);
    int c;
    int ss;
    ss = t0 + 1 + st_after;
    for (int k = 0; k < nw; k++) begin
      c = t0 + 1 + k;
      if (c >= ss) c += st_len;
      if (big) wq64.push_back('{c, k % nx, k / nx});
      else wq4.push_back('{c, k % nx, k / nx});
    end
    c = 0;
    for (int k = 0; k < nr; k++) begin
      c = t0 + 3 + k;
      if (c >= ss) c += st_len;
      if (big) rq64.push_back('{c, k % nx, k / nx});
      else rq4.push_back('{c, k % nx, k / nx});
    end
    if (with_done) begin
      if (big) dq64.push_back(c + 1);
      else dq4.push_back(c + 1);
    end
  endtask

  initial begin
    int t0;
    {if4.start, if4.stall, if4.flush, if64.start, if64.stall, if64.flush} = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset4", int'({if4.write_wen, if4.read_ren, if4.busy, if4.done,
                               |if4.write_ctrl_vars, |if4.read_ctrl_vars}), 0);
    check_val("reset64", int'({if64.write_wen, if64.read_ren, if64.busy, if64.done,
                                |if64.write_ctrl_vars, |if64.read_ctrl_vars}), 0);
    rst_n = 1;
    launch(0, t0);
    push_run(0, t0, 4, 16, 16, 100000, 0, 1);
    check_val("busy_run", int'(if4.busy), 1);
    repeat (25) @(posedge clk);
    expect_empty("basic_left");
    launch(0, t0);
    push_run(0, t0, 4, 16, 16, 5, 3, 1);
    repeat (5) @(posedge clk);
    #1 if4.stall = 1;
    repeat (3) @(posedge clk);
    #1 if4.stall = 0;
    repeat (25) @(posedge clk);
    expect_empty("stall_left");
    launch(0, t0);
    push_run(0, t0, 4, 16, 16, 100000, 0, 1);
    repeat (4) @(posedge clk);
    #1 if4.start = 1;
    @(posedge clk);
    #1 if4.start = 0;
    repeat (25) @(posedge clk);
    expect_empty("restart_left");
    launch(0, t0);
    push_run(0, t0, 4, 8, 6, 100000, 0, 0);
    repeat (7) @(posedge clk);
    #1 if4.flush = 1;
    @(posedge clk);
    #1 if4.flush = 0;
    check_val("flush_busy", int'(if4.busy), 0);
    check_val("flush_wen", int'(if4.write_wen), 0);
    repeat (25) @(posedge clk);
    expect_empty("flush_left");
    launch(0, t0);
    push_run(0, t0, 4, 16, 16, 100000, 0, 1);
    repeat (25) @(posedge clk);
    expect_empty("post_flush_left");
    launch(1, t0);
    push_run(1, t0, 64, 5, 3, 100000, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check_val("midrun_reset", int'({if64.write_wen, if64.read_ren, if64.busy, if64.done,
                                     |if64.write_ctrl_vars, |if64.read_ctrl_vars}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (5) @(posedge clk);
    expect_empty("reset_left");
    check_val("idle_after_reset", int'(if64.busy), 0);
    launch(1, t0);
    push_run(1, t0, 64, 4096, 4096, 100000, 0, 1);
    repeat (4110) @(posedge clk);
    expect_empty("full_left");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ub_schedule_ctrl.md
UB_SCHEDULE_CTRL -- requirements
Module: ub_schedule_ctrl

Interface
REQ-001 SHALL have parameter X_EXTENT, default 64, meaning the innermost loop trip count (ctrl_vars[1]).
REQ-002 SHALL have parameter Y_EXTENT, default 64, meaning the outer loop trip count (ctrl_vars[2]).
REQ-003 SHALL have parameter RD_DELAY, default 2, range 1..255, meaning write-to-read schedule offset in active cycles.
REQ-004 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port flush, input, 1, synchronous abort to IDLE.
REQ-007 SHALL have port start, input, 1, one-cycle launch request.
REQ-008 SHALL have port stall, input, 1, freezes all schedule progress while high.
REQ-009 SHALL have port write_wen, output, 1, producer write strobe to the buffer.
REQ-010 SHALL have port write_ctrl_vars, output, 3x16, producer loop indices [0]=root, [1]=x, [2]=y.
REQ-011 SHALL have port read_ren, output, 1, consumer read strobe to the buffer.
REQ-012 SHALL have port read_ctrl_vars, output, 3x16, consumer loop indices, same layout.
REQ-013 SHALL have port busy, output, 1, high in RUN or DRAIN.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start, RUN->DRAIN after last write, DRAIN->DONE after last read, DONE->IDLE unconditionally next cycle.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL assert write_wen in the first cycle after the edge sampling start in IDLE, with write_ctrl_vars = (0,0,0).
REQ-018 SHALL advance write indices once per non-stalled RUN cycle, x innermost: x wraps X_EXTENT-1->0 and increments y.
REQ-019 SHALL hold ctrl_vars[0] at 0 on both ports.
REQ-020 SHALL issue exactly X_EXTENT*Y_EXTENT write strobes per launch, last with (0, X_EXTENT-1, Y_EXTENT-1).
REQ-021 SHALL assert read_ren exactly RD_DELAY non-stalled cycles after the matching write strobe, with identical indices.
REQ-022 SHALL issue exactly X_EXTENT*Y_EXTENT read strobes, read never ahead of write for any index.
REQ-023 SHALL, while stall is high, deassert write_wen and read_ren and hold all counters and the delay state; resume without loss or duplication.
REQ-024 SHALL pulse done in the cycle after the last read strobe; busy low in that cycle.
REQ-025 SHALL on flush clear counters, deassert strobes next cycle, return to IDLE without done; flush beats start in the same cycle.
REQ-026 SHALL keep all counters 16-bit unsigned; no index exceeds extent-1.
REQ-027 SHALL drive ctrl_vars to 0 whenever the corresponding strobe is low.

Reset
REQ-028 SHALL on rst_n low asynchronously enter IDLE; write_wen, read_ren, busy, done = 0; all ctrl_vars = 0.
REQ-029 SHALL, on reset mid-run, discard the schedule; first post-reset activity requires a new start.

Structure
REQ-030 SHALL take state enum, CTRL_W=16 and NUM_DIMS=3 from shared package ub_ctrl_pkg.
REQ-031 SHALL instantiate one loop-nest counter sub-module ub_loop_counter twice (write side, read side), with read side enabled by a RD_DELAY-deep valid shift register.

Verification
REQ-032 SHALL check: start with X=Y=4, RD_DELAY=2 -> 16 writes cycles 1..16, 16 reads cycles 3..18, done at cycle 19.
REQ-033 SHALL check: index sequence for X=4 -> write x 0,1,2,3,0 with y 0,0,0,0,1.
REQ-034 SHALL check: stall high 3 cycles after 5th write -> no strobes for 3 cycles, 6th write index (0,1,1), totals still 16/16, done delayed by 3.
REQ-035 SHALL check: start pulsed during RUN -> ignored; strobe counts unchanged.
REQ-036 SHALL check: flush at cycle 8 -> strobes low from cycle 9, no done, busy low; new start gives full 16/16 run.
REQ-037 SHALL check: rst_n low at cycle 6 -> outputs 0 immediately; default 64x64 run afterwards yields 4096 writes, last read (0,63,63), done at cycle 4099.
